motor_pwm_drive: RTL and testbench
==================================

# motor_pwm_drive

Parametrised N-channel DC-motor drive for the two-wheel platform, placed between the ibex_sys IO/PWM registers and the H-bridge pins.
- Generates per-channel PWM on the bridge enable.
- Inserts a dead-time brake whenever a running channel reverses direction.
- Counts wheel-encoder events per channel with saturation.

It generalises the fixed two-motor direction/enable glue to any channel count, PWM resolution and dead time.

## Interface
Parameters:
- N_CH, 2, number of motor channels
- PWM_W, 8, PWM counter/duty width; period = 2^PWM_W ticks
- PRESC, 16, clock cycles per PWM tick (>=1)
- DEAD_CYC, 256, clock cycles of forced-off time on direction reversal (>=1)
- CNT_W, 16, width of each encoder event counter

Ports:
- Clk  in  1  system clock; single clock domain
- sys_rst  in  1  reset, synchronous, active-high
- en  in  N_CH  per-channel run request
- force_on  in  1  global run request (button override), ORed with every en[i]
- dir  in  N_CH  requested direction
- duty  in  N_CH*PWM_W  duty of channel i in bits [i*PWM_W +: PWM_W]
- evnt  in  N_CH  asynchronous encoder pulses
- cnt_clr  in  N_CH  synchronous clear of evnt_cnt[i]
- mt  out  2*N_CH  bridge direction pair {mt[2i+1],mt[2i]}: 2'b01 if dir_q[i]=1, 2'b10 if 0
- en_out  out  N_CH  bridge enable (PWM-gated)
- busy  out  N_CH  channel i is in dead time
- evnt_cnt  out  N_CH*CNT_W  encoder count of channel i in [i*CNT_W +: CNT_W]

## Operation
- **Prescaler:**
  - Shared counter 0..PRESC-1; tick asserted on the cycle it equals PRESC-1, then it wraps to 0.
  - PRESC=1: tick every cycle.
- **PWM:**
  - Shared pwm_cnt (PWM_W bits) increments on tick and wraps from all-ones to 0.
  - Duty latch per channel, duty_q[i] <= duty[i] on the tick where pwm_cnt wraps to 0; changes mid-period take effect next period.
  - Registered pwm_bit[i] <= (pwm_cnt < duty_q[i]).
  - duty=0: never high. All-ones: high 2^PWM_W-1 of 2^PWM_W ticks.
- **Per-channel FSM**, req[i] = en[i] | force_on:
  - IDLE: en_out=0. dir_q <= dir every cycle. req -> RUN.
  - RUN: en_out = pwm_bit. !req -> IDLE. dir != dir_q -> DEAD, clearing dead_cnt; reversal has priority over !req.
  - DEAD: en_out=0, busy=1, dead_cnt increments.
    - At dead_cnt = DEAD_CYC-1: dir_q <= current dir, then -> RUN if req else IDLE.
    - dir toggling back during DEAD does not shorten or restart dead time.
- mt is decoded only from dir_q (a flop), so it never changes while en_out can be 1.
- **Encoder:**
  - evnt[i] passes a 2-flop synchroniser plus a previous-value flop.
  - A rising edge increments evnt_cnt[i], saturating at all-ones.
  - cnt_clr[i] clears to 0 and wins over a simultaneous increment.

## Timing
- Reset, synchronous, while sys_rst=1 at an edge:
  - Values: state=IDLE, dir_q=0, duty_q=0, pwm_cnt=0, prescaler=0, dead_cnt=0, pwm_bit=0, synchronisers=0, evnt_cnt=0.
  - Outputs: en_out=0, busy=0, mt pair=2'b10.
  - Reset during DEAD or RUN forces IDLE at that edge.
- Run latency: req rising before edge k gives state RUN after edge k; en_out follows pwm_bit from that cycle.
- Stop latency: req falling before edge k gives en_out=0 after edge k.
- Reversal:
  - dir change in RUN before edge k: en_out=0 and busy=1 after edge k.
  - mt flips and busy falls after edge k+DEAD_CYC.
  - Total off time is exactly DEAD_CYC cycles.
- Encoder: evnt rising, sampled at edge k, gives evnt_cnt +1 after edge k+2. Pulses must be high and low for at least 2 cycles each.
- Channels are fully independent except for the shared prescaler and pwm_cnt. All channels are phase-aligned.

## Test plan
Bench parameters: N_CH=2, PWM_W=4, PRESC=1, DEAD_CYC=8, CNT_W=4.
- **Reset values:** hold sys_rst 3 cycles with random inputs. Required: en_out=0, busy=0, mt=4'b1010, evnt_cnt=0.
- **PWM duty:**
  - ch0 en=1, duty=4: en_out[0] high exactly 4 of every 16 cycles.
  - duty=0: always 0.
  - duty=15: 15 of 16.
  - Change duty 4 -> 10 mid-period: new width only from the next pwm_cnt wrap.
- **Reversal in RUN:**
  - ch1 running at duty=15, toggle dir[1] 0->1: en_out[1]=0 and busy[1]=1 for exactly 8 cycles; mt[3:2] goes 10 -> 01 at the end; PWM resumes.
  - Toggle dir back mid-dead: still 8 cycles; final mt = 10.
- **Override and stop:**
  - en=0, force_on=1: both channels run.
  - Drop force_on: both en_out=0 next cycle.
  - Drop req during DEAD: channel ends dead time in IDLE.
- **Encoder saturation and clear:**
  - 20 pulses on evnt[0]: evnt_cnt[0] saturates at 15.
  - cnt_clr[0] coincident with an edge: result is 0.
  - Next pulse: result is 1, arriving 3 cycles after the pulse edge.
- **Reset mid-DEAD:** assert sys_rst during dead time. Required: IDLE, busy=0, mt=4'b1010 next cycle.

Source files
------------

// File: rtl/motor_pwm_drive.sv
// N-channel H-bridge drive: shared prescaler/PWM counter, per-channel run/dead-time FSM, saturating encoder counters.
// en_out/busy follow the state register with no extra latency; encoder edges land in evnt_cnt two cycles after sampling.
module motor_pwm_drive #(
  parameter int N_CH     = 2,
  parameter int PWM_W    = 8,
  parameter int PRESC    = 16,
  parameter int DEAD_CYC = 256,
  parameter int CNT_W    = 16
) (
  input  logic                    Clk,
  input  logic                    sys_rst,
  input  logic [N_CH-1:0]         en,
  input  logic                    force_on,
  input  logic [N_CH-1:0]         dir,
  input  logic [N_CH*PWM_W-1:0]   duty,
  input  logic [N_CH-1:0]         evnt,
  input  logic [N_CH-1:0]         cnt_clr,
  output logic [2*N_CH-1:0]       mt,
  output logic [N_CH-1:0]         en_out,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH*CNT_W-1:0]   evnt_cnt
);

  localparam int PS_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESC - 1);
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEAD_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t                         state_q [N_CH];
  state_t                         state_d [N_CH];
  logic [PS_W-1:0]                presc_q, presc_d;
  logic [PWM_W-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [N_CH-1:0][PWM_W-1:0]     duty_q, duty_d;
  logic [N_CH-1:0][DC_W-1:0]      dead_cnt_q, dead_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0]                dir_q, dir_d;
  logic [N_CH-1:0]                pwm_bit_q, pwm_bit_d;
  logic [N_CH-1:0]                sync1_q, sync1_d;
  logic [N_CH-1:0]                sync2_q, sync2_d;
  logic [N_CH-1:0]                prev_q, prev_d;
  logic                           tick;
  logic                           wrap;

  assign tick = (presc_q == PS_MAX);
  assign wrap = tick && (pwm_cnt_q == '1);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    // Duty is only sampled at the period boundary so a period is never cut short.
    duty_d     = wrap ? duty : duty_q;
    sync1_d    = evnt;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    cnt_d      = cnt_q;
    pwm_bit_d  = '0;
    en_out     = '0;
    busy       = '0;
    mt         = '0;
    evnt_cnt   = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]   = state_q[i];
      pwm_bit_d[i] = (pwm_cnt_q < duty_q[i]);

      if (cnt_clr[i]) begin
        cnt_d[i] = '0;
      end else if (sync2_q[i] && !prev_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      case (state_q[i])
        IDLE: begin
          dir_d[i] = dir[i];
          if (en[i] || force_on) state_d[i] = RUN;
        end
        RUN: begin
          if (dir[i] != dir_q[i]) begin
            state_d[i]    = DEAD;
            dead_cnt_d[i] = '0;
          end else if (!(en[i] || force_on)) begin
            state_d[i] = IDLE;
          end
        end
        DEAD: begin
          // Direction changes during dead time are ignored until it expires.
          if (dead_cnt_q[i] == DC_MAX) begin
            dir_d[i]      = dir[i];
            dead_cnt_d[i] = '0;
            state_d[i]    = (en[i] || force_on) ? RUN : IDLE;
          end else begin
            dead_cnt_d[i] = dead_cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      en_out[i]                   = (state_q[i] == RUN) && pwm_bit_q[i];
      busy[i]                     = (state_q[i] == DEAD);
      mt[2*i+1]                   = ~dir_q[i];
      mt[2*i]                     = dir_q[i];
      evnt_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= IDLE;
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dead_cnt_q <= '0;
      cnt_q      <= '0;
      dir_q      <= '0;
      pwm_bit_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dead_cnt_q <= dead_cnt_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      pwm_bit_q  <= pwm_bit_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
    end
  end

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive with N_CH=2, PWM_W=4, PRESC=1, DEAD_CYC=8, CNT_W=4.
module tb_motor_pwm_drive;

  logic       Clk = 1'b0;
  logic       sys_rst;
  logic [1:0] en;
  logic       force_on;
  logic [1:0] dir;
  logic [7:0] duty;
  logic [1:0] evnt;
  logic [1:0] cnt_clr;
  logic [3:0] mt;
  logic [1:0] en_out;
  logic [1:0] busy;
  logic [7:0] evnt_cnt;

  int n_vec = 0;
  int n_err = 0;

  motor_pwm_drive #(
    .N_CH(2), .PWM_W(4), .PRESC(1), .DEAD_CYC(8), .CNT_W(4)
  ) dut (
    .Clk(Clk), .sys_rst(sys_rst), .en(en), .force_on(force_on), .dir(dir),
    .duty(duty), .evnt(evnt), .cnt_clr(cnt_clr), .mt(mt), .en_out(en_out),
    .busy(busy), .evnt_cnt(evnt_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic count_hi(input int ch, input int n, output int hits);
    hits = 0;
    for (int k = 0; k < n; k++) begin
      step();
      hits += int'(en_out[ch]);
    end
  endtask

  task automatic wait_rise(input int ch, output bit ok);
    logic prev;
    prev = en_out[ch];
    ok = 1'b0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (!prev && en_out[ch]) begin
        ok = 1'b1;
        break;
      end
      prev = en_out[ch];
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en       = 2'($urandom);
      force_on = 1'($urandom);
      dir      = 2'($urandom);
      duty     = 8'($urandom);
      evnt     = 2'($urandom);
      cnt_clr  = 2'($urandom);
      step();
    end
    n_vec++; if (en_out !== 2'b00) begin n_err++; $display("FAIL reset_en_out: got %b want 00", en_out); end
    n_vec++; if (busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b want 00", busy); end
    n_vec++; if (mt !== 4'b1010) begin n_err++; $display("FAIL reset_mt: got %b want 1010", mt); end
    n_vec++; if (evnt_cnt !== 8'h00) begin n_err++; $display("FAIL reset_evnt_cnt: got %h want 00", evnt_cnt); end
    en = '0; force_on = 1'b0; dir = '0; duty = '0; evnt = '0; cnt_clr = '0;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_pwm_duty();
    int h;
    bit ok;
    en[0] = 1'b1;
    duty[3:0] = 4'd4;
    wait_rise(0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pwm_start: en_out[0] rise seen=%0d want 1", ok); end
    count_hi(0, 15, h);
    h += 1;
    n_vec++; if (h !== 4) begin n_err++; $display("FAIL pwm_duty4_p1: high %0d want 4", h); end
    count_hi(0, 16, h);
    n_vec++; if (h !== 4) begin n_err++; $display("FAIL pwm_duty4_p2: high %0d want 4", h); end

    duty[3:0] = 4'd0;
    count_hi(0, 32, h);
    count_hi(0, 16, h);
    n_vec++; if (h !== 0) begin n_err++; $display("FAIL pwm_duty0: high %0d want 0", h); end

    duty[3:0] = 4'd15;
    count_hi(0, 32, h);
    count_hi(0, 16, h);
    n_vec++; if (h !== 15) begin n_err++; $display("FAIL pwm_duty15: high %0d want 15", h); end

    duty[3:0] = 4'd4;
    count_hi(0, 32, h);
    wait_rise(0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pwm_mid_rise: rise seen=%0d want 1", ok); end
    h = 1;
    for (int k = 0; k < 15; k++) begin
      if (k == 5) duty[3:0] = 4'd10;
      step();
      h += int'(en_out[0]);
    end
    n_vec++; if (h !== 4) begin n_err++; $display("FAIL pwm_mid_old: high %0d want 4", h); end
    count_hi(0, 16, h);
    n_vec++; if (h !== 10) begin n_err++; $display("FAIL pwm_mid_new: high %0d want 10", h); end
    en[0] = 1'b0;
    step();
    n_vec++; if (en_out[0] !== 1'b0) begin n_err++; $display("FAIL pwm_stop: got %b want 0", en_out[0]); end
  endtask

  task automatic test_reversal();
    int h;
    int bad;
    en[1] = 1'b1;
    duty[7:4] = 4'd15;
    dir[1] = 1'b0;
    count_hi(1, 32, h);
    count_hi(1, 16, h);
    n_vec++; if (h !== 15) begin n_err++; $display("FAIL rev_pre_pwm: high %0d want 15", h); end
    n_vec++; if (mt[3:2] !== 2'b10) begin n_err++; $display("FAIL rev_pre_mt: got %b want 10", mt[3:2]); end

    dir[1] = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (busy[1] !== 1'b1 || en_out[1] !== 1'b0 || mt[3:2] !== 2'b10) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rev_dead: %0d bad dead cycles want 0", bad); end
    step();
    n_vec++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL rev_busy_end: got %b want 0", busy[1]); end
    n_vec++; if (mt[3:2] !== 2'b01) begin n_err++; $display("FAIL rev_mt_end: got %b want 01", mt[3:2]); end
    count_hi(1, 16, h);
    n_vec++; if (h !== 15) begin n_err++; $display("FAIL rev_resume: high %0d want 15", h); end

    dir[1] = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) dir[1] = 1'b1;
      if (k == 5) dir[1] = 1'b0;
      step();
      if (busy[1] !== 1'b1 || en_out[1] !== 1'b0 || mt[3:2] !== 2'b01) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rev_toggle_dead: %0d bad dead cycles want 0", bad); end
    step();
    n_vec++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL rev_toggle_busy: got %b want 0", busy[1]); end
    n_vec++; if (mt[3:2] !== 2'b10) begin n_err++; $display("FAIL rev_toggle_mt: got %b want 10", mt[3:2]); end
    en[1] = 1'b0;
    step();
  endtask

  task automatic test_override();
    int h0;
    int h1;
    int tmp;
    duty = 8'hFF;
    en = 2'b00;
    force_on = 1'b1;
    count_hi(0, 32, tmp);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      h0 += int'(en_out[0]);
      h1 += int'(en_out[1]);
    end
    n_vec++; if (h0 !== 15) begin n_err++; $display("FAIL ovr_ch0: high %0d want 15", h0); end
    n_vec++; if (h1 !== 15) begin n_err++; $display("FAIL ovr_ch1: high %0d want 15", h1); end
    force_on = 1'b0;
    step();
    n_vec++; if (en_out !== 2'b00) begin n_err++; $display("FAIL ovr_drop: got %b want 00", en_out); end
  endtask

  task automatic test_drop_in_dead();
    int h;
    int bad;
    force_on = 1'b1;
    step(); step(); step();
    dir[1] = 1'b1;
    step();
    n_vec++; if (busy[1] !== 1'b1) begin n_err++; $display("FAIL drop_dead_enter: got %b want 1", busy[1]); end
    force_on = 1'b0;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (busy[1] !== 1'b1 || en_out[1] !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL drop_dead_len: %0d bad cycles want 0", bad); end
    step();
    n_vec++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL drop_dead_end: got %b want 0", busy[1]); end
    n_vec++; if (mt[3:2] !== 2'b01) begin n_err++; $display("FAIL drop_dead_mt: got %b want 01", mt[3:2]); end
    count_hi(1, 16, h);
    n_vec++; if (h !== 0) begin n_err++; $display("FAIL drop_dead_idle: high %0d want 0", h); end
  endtask

  task automatic test_encoder();
    for (int p = 0; p < 20; p++) begin
      evnt[0] = 1'b1;
      step(); step();
      evnt[0] = 1'b0;
      step(); step();
    end
    step(); step(); step();
    n_vec++; if (evnt_cnt[3:0] !== 4'd15) begin n_err++; $display("FAIL enc_sat: got %0d want 15", evnt_cnt[3:0]); end
    n_vec++; if (evnt_cnt[7:4] !== 4'd0) begin n_err++; $display("FAIL enc_ch1_quiet: got %0d want 0", evnt_cnt[7:4]); end

    evnt[0] = 1'b1;
    step(); step();
    cnt_clr[0] = 1'b1;
    step();
    cnt_clr[0] = 1'b0;
    n_vec++; if (evnt_cnt[3:0] !== 4'd0) begin n_err++; $display("FAIL enc_clr_wins: got %0d want 0", evnt_cnt[3:0]); end
    step(); step();
    evnt[0] = 1'b0;
    step(); step(); step();
    n_vec++; if (evnt_cnt[3:0] !== 4'd0) begin n_err++; $display("FAIL enc_clr_hold: got %0d want 0", evnt_cnt[3:0]); end

    evnt[0] = 1'b1;
    step(); step();
    n_vec++; if (evnt_cnt[3:0] !== 4'd0) begin n_err++; $display("FAIL enc_early: got %0d want 0", evnt_cnt[3:0]); end
    step();
    n_vec++; if (evnt_cnt[3:0] !== 4'd1) begin n_err++; $display("FAIL enc_next: got %0d want 1", evnt_cnt[3:0]); end
    step();
    evnt[0] = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_dead();
    en[1] = 1'b1;
    dir[1] = 1'b1;
    step(); step();
    dir[1] = 1'b0;
    step(); step();
    n_vec++; if (busy[1] !== 1'b1) begin n_err++; $display("FAIL rst_dead_pre: got %b want 1", busy[1]); end
    sys_rst = 1'b1;
    step();
    n_vec++; if (busy !== 2'b00) begin n_err++; $display("FAIL rst_dead_busy: got %b want 00", busy); end
    n_vec++; if (en_out !== 2'b00) begin n_err++; $display("FAIL rst_dead_en_out: got %b want 00", en_out); end
    n_vec++; if (mt !== 4'b1010) begin n_err++; $display("FAIL rst_dead_mt: got %b want 1010", mt); end
    n_vec++; if (evnt_cnt !== 8'h00) begin n_err++; $display("FAIL rst_dead_cnt: got %h want 00", evnt_cnt); end
    en = '0;
    sys_rst = 1'b0;
    step();
  endtask

  initial begin
    sys_rst = 1'b1; en = '0; force_on = 1'b0; dir = '0; duty = '0; evnt = '0; cnt_clr = '0;
    test_reset();
    test_pwm_duty();
    test_reversal();
    test_override();
    test_drop_in_dead();
    test_encoder();
    test_reset_mid_dead();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
